// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin arbiter sharing one registered valid/ready stream sink among NUM_REQ requesters
// Ports:
//   clk        rising-edge clock
//   rstb       asynchronous active-low reset
//   in_valid   per-requester beat valid
//   in_data    per-requester data, requester i on in_data[i*DW +: DW]
//   in_ready   per-requester accept (combinational, only the owner can be ready)
//   out_valid  registered output beat valid
//   out_data   registered output data
//   out_ready  downstream accept
//   grant_id   index of the current or last owner (registered)
//   busy       high while a requester holds the grant (registered)
module rr_stream_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DW        = 4,
    parameter int MAX_BURST = 4,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [NUM_REQ-1:0]    in_valid,
    input  logic [NUM_REQ*DW-1:0] in_data,
    output logic [NUM_REQ-1:0]    in_ready,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    input  logic                  out_ready,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam int CW = 8;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    logic [0:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    logic           found;
    logic [CW-1:0]  beat_cnt;
    logic           slot_open;
    logic           owner_valid;
    logic           xfer;
    logic           release_grant;
    logic [DW-1:0]  owner_data;

    // First requesting index at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        sel = rr_ptr;
        found = 1'b0;
        idx = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && in_valid[idx]) begin
                sel = idx;
                found = 1'b1;
            end
            idx = (idx == LAST_ID) ? '0 : idx + 1'b1;
        end
    end

    assign slot_open = !out_valid || out_ready;

    // Owner mux built from explicit compares so non-owner data can never leak through.
    always_comb begin
        owner_valid = 1'b0;
        owner_data = '0;
        in_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                owner_valid = in_valid[i];
                owner_data = in_data[i*DW +: DW];
                in_ready[i] = (state == GRANT) && slot_open;
            end
        end
    end

    assign xfer = (state == GRANT) && owner_valid && slot_open;
    // The owner dropping valid releases even when the output slot is blocked.
    assign release_grant = (state == GRANT) && (!owner_valid || (xfer && beat_cnt == LAST_BEAT));
    assign busy = (state == GRANT);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            grant_id  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= owner_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // A release always returns to IDLE; the next owner is chosen there.
            if (state == IDLE) begin
                if (|in_valid) begin
                    state    <= GRANT;
                    grant_id <= sel;
                    beat_cnt <= '0;
                end
            end else if (release_grant) begin
                state    <= IDLE;
                rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter: bench for rr_stream_arbiter, MAX_BURST=4 (dut0) and MAX_BURST=1 (dut1) on shared inputs
module tb_rr_stream_arbiter;
    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic [3:0]  in_valid = '0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b1;
    logic [3:0]  rdy0, rdy1, od0, od1;
    logic        ov0, ov1, bsy0, bsy1;
    logic [1:0]  gid0, gid1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_stream_arbiter #(.NUM_REQ(4), .DW(4), .MAX_BURST(4)) dut0 (
        .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .out_valid(ov0), .out_data(od0), .out_ready(out_ready), .grant_id(gid0), .busy(bsy0)
    );

    rr_stream_arbiter #(.NUM_REQ(4), .DW(4), .MAX_BURST(1)) dut1 (
        .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
        .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .grant_id(gid1), .busy(bsy1)
    );

    // Reference model: owner is -1 when nobody holds the grant.
    int         m_owner [2];
    int         m_ptr [2];
    int         m_cnt [2];
    int         m_last [2];
    bit         m_ov [2];
    logic [3:0] m_od [2];

    function automatic int burst_of(int m);
        return (m == 0) ? 4 : 1;
    endfunction

    always @(posedge clk or negedge rstb) begin
        int  o;
        bit  take;
        if (!rstb) begin
            for (int m = 0; m < 2; m++) begin
                m_owner[m] = -1;
                m_ptr[m] = 0;
                m_cnt[m] = 0;
                m_last[m] = 0;
                m_ov[m] = 0;
                m_od[m] = '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                o = m_owner[m];
                take = (o >= 0) && in_valid[o] && (!m_ov[m] || out_ready);
                if (take) begin
                    m_ov[m] = 1;
                    m_od[m] = in_data[o*4 +: 4];
                end else if (out_ready) begin
                    m_ov[m] = 0;
                end
                if (o < 0) begin
                    for (int j = 3; j >= 0; j--)
                        if (in_valid[(m_ptr[m] + j) % 4]) m_owner[m] = (m_ptr[m] + j) % 4;
                    if (m_owner[m] >= 0) begin
                        m_last[m] = m_owner[m];
                        m_cnt[m] = 0;
                    end
                end else if (!in_valid[o] || (take && m_cnt[m] + 1 == burst_of(m))) begin
                    m_ptr[m] = (o + 1) % 4;
                    m_owner[m] = -1;
                    m_cnt[m] = 0;
                end else if (take) begin
                    m_cnt[m]++;
                end
            end
        end
    end

    function automatic logic [11:0] mdl_obs(int m);
        logic [3:0] r = '0;
        if (m_owner[m] >= 0 && (!m_ov[m] || out_ready)) r[m_owner[m]] = 1'b1;
        return {m_owner[m] >= 0, 2'(m_last[m]), m_ov[m], m_ov[m] ? m_od[m] : 4'h0, r};
    endfunction

    function automatic logic [11:0] dut_obs(int m);
        return (m == 0) ? {bsy0, gid0, ov0, ov0 ? od0 : 4'h0, rdy0}
                        : {bsy1, gid1, ov1, ov1 ? od1 : 4'h0, rdy1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        in_valid = '0;
        tick();
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({bsy0, gid0, ov0, od0, rdy0, bsy1, gid1, ov1, od1, rdy1} !== 24'h0) begin
            failures++;
            $display("FAIL reset_state got=%h required=0", {bsy0, gid0, ov0, od0, rdy0, bsy1, gid1, ov1, od1, rdy1});
        end
        rstb = 1'b1;
        in_valid = 4'hf;
        in_data = 16'h4321;
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dut_obs(m) !== mdl_obs(m)) begin
                    failures++;
                    $display("FAIL reset_stream dut%0d t=%0t got=%h required=%h", m, $time, dut_obs(m), mdl_obs(m));
                end
            end
        end
        checks++;
        if (ov0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_precond out_valid got=%b required=1", ov0);
        end
        rstb = 1'b0;
        #1;
        checks++;
        if ({bsy0, gid0, ov0, od0, rdy0, bsy1, gid1, ov1, od1, rdy1} !== 24'h0) begin
            failures++;
            $display("FAIL reset_async got=%h required=0", {bsy0, gid0, ov0, od0, rdy0, bsy1, gid1, ov1, od1, rdy1});
        end
        tick();
        rstb = 1'b1;
        in_valid = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (rdy0 !== 4'h0 || ov0 !== 1'b0 || rdy1 !== 4'h0 || ov1 !== 1'b0) begin
                failures++;
                $display("FAIL idle c=%0d got rdy=%h/%h ov=%b/%b required 0", c, rdy0, rdy1, ov0, ov1);
            end
        end
    endtask

    task automatic test_single_burst();
        logic [3:0] beats[$];
        logic [8:0] ov_trace = '0;
        int k = 0;
        bit acc;
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            in_valid = (k < 6) ? 4'b0100 : 4'b0000;
            in_data = 16'($urandom);
            in_data[11:8] = 4'(k + 1);
            #1;
            acc = rdy0[2] && in_valid[2];
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dut_obs(m) !== mdl_obs(m)) begin
                    failures++;
                    $display("FAIL burst_model dut%0d t=%0t got=%h required=%h", m, $time, dut_obs(m), mdl_obs(m));
                end
            end
            ov_trace[8-c] = ov0;
            if (ov0) beats.push_back(od0);
            if (bsy0 && gid0 !== 2'd2) begin
                checks++;
                failures++;
                $display("FAIL burst_grant c=%0d got=%0d required=2", c, gid0);
            end
            if (acc) k++;
        end
        checks++;
        if (ov_trace !== 9'b011110110) begin
            failures++;
            $display("FAIL burst_bubble out_valid trace got=%b required=011110110", ov_trace);
        end
        checks++;
        if (beats.size() != 6) begin
            failures++;
            $display("FAIL burst_count got=%0d required=6", beats.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (beats[i] !== 4'(i + 1)) begin
                    failures++;
                    $display("FAIL burst_data beat%0d got=%h required=%h", i, beats[i], 4'(i + 1));
                end
            end
        end
    endtask

    task automatic test_fairness();
        logic [1:0] gr[$];
        int rise[$];
        logic [3:0] beats[$];
        int eg [5] = '{0, 1, 2, 3, 0};
        logic prev = 1'b0;
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'hf;
        in_data = 16'hDCBA;
        for (int c = 0; c < 26; c++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dut_obs(m) !== mdl_obs(m)) begin
                    failures++;
                    $display("FAIL fair_model dut%0d t=%0t got=%h required=%h", m, $time, dut_obs(m), mdl_obs(m));
                end
            end
            if (bsy0 && !prev) begin
                gr.push_back(gid0);
                rise.push_back(c);
            end
            prev = bsy0;
            if (ov0) beats.push_back(od0);
        end
        checks++;
        if (gr.size() < 5 || beats.size() < 20) begin
            failures++;
            $display("FAIL fair_count grants=%0d beats=%0d required >=5 and >=20", gr.size(), beats.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (gr[i] !== 2'(eg[i])) begin
                    failures++;
                    $display("FAIL fair_order grant%0d got=%0d required=%0d", i, gr[i], eg[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (rise[i] - rise[i-1] != 5) begin
                        failures++;
                        $display("FAIL fair_spacing grant%0d got=%0d required=5", i, rise[i] - rise[i-1]);
                    end
                end
            end
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (beats[i] !== 4'(10 + (i / 4) % 4)) begin
                    failures++;
                    $display("FAIL fair_data beat%0d got=%h required=%h", i, beats[i], 4'(10 + (i / 4) % 4));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] sent[$];
        logic [3:0] got[$];
        int k = 0;
        int grants = 0;
        int first = 0;
        bit done = 0;
        bit acc, cons;
        logic prev = 1'b0;
        do_reset();
        for (int c = 0; c < 60 && !done; c++) begin
            out_ready = (c >= 3 && c <= 5) ? 1'b0 : (c < 6 ? 1'b1 : 1'($urandom_range(0, 1)));
            in_valid = (k < 8) ? 4'b0010 : 4'b0000;
            in_data = 16'($urandom);
            in_data[7:4] = 4'(k * 3 + 1);
            #1;
            if (c >= 3 && c <= 5) begin
                checks++;
                if (rdy0 !== 4'h0 || ov0 !== 1'b1 || od0 !== sent[$]) begin
                    failures++;
                    $display("FAIL stall c=%0d got rdy=%h ov=%b od=%h required rdy=0 ov=1 od=%h", c, rdy0, ov0, od0, sent[$]);
                end
            end
            acc = rdy0[1] && in_valid[1];
            cons = ov0 && out_ready;
            if (acc) begin
                sent.push_back(in_data[7:4]);
                if (grants == 1) first++;
            end
            if (cons) got.push_back(od0);
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dut_obs(m) !== mdl_obs(m)) begin
                    failures++;
                    $display("FAIL bp_model dut%0d t=%0t got=%h required=%h", m, $time, dut_obs(m), mdl_obs(m));
                end
            end
            if (bsy0 && !prev) grants++;
            prev = bsy0;
            done = (k >= 8) && !ov0 && !bsy0;
            if (acc) k++;
            done = done && (k >= 8);
        end
        out_ready = 1'b1;
        checks++;
        if (!done || sent.size() != 8 || got.size() != 8) begin
            failures++;
            $display("FAIL bp_drain done=%b sent=%0d got=%0d required 1/8/8", done, sent.size(), got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++;
                    $display("FAIL bp_order beat%0d got=%h required=%h", i, got[i], sent[i]);
                end
            end
        end
        checks++;
        if (first != 4) begin
            failures++;
            $display("FAIL bp_burst_len got=%0d required=4", first);
        end
    endtask

    task automatic test_early_release();
        logic [3:0] vt [5] = '{4'b1010, 4'b1010, 4'b1010, 4'b1001, 4'b1001};
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            in_valid = (c < 5) ? vt[c] : 4'b0000;
            in_data = 16'($urandom);
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dut_obs(m) !== mdl_obs(m)) begin
                    failures++;
                    $display("FAIL early_model dut%0d t=%0t got=%h required=%h", m, $time, dut_obs(m), mdl_obs(m));
                end
            end
            if (c == 0 || c == 3 || c == 4) begin
                checks++;
                if ({bsy0, gid0} !== ((c == 0) ? 3'b101 : (c == 3) ? 3'b001 : 3'b111)) begin
                    failures++;
                    $display("FAIL early_grant c=%0d got busy=%b id=%0d", c, bsy0, gid0);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] gr[$];
        logic [3:0] beats[$];
        logic prev = 1'b0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c == 0) ? 4'b1000 : 4'b1001;
            in_data = 16'($urandom);
            in_data[3:0] = 4'h5;
            in_data[15:12] = 4'h9;
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dut_obs(m) !== mdl_obs(m)) begin
                    failures++;
                    $display("FAIL wrap_model dut%0d t=%0t got=%h required=%h", m, $time, dut_obs(m), mdl_obs(m));
                end
            end
            if (bsy1 && !prev) gr.push_back(gid1);
            prev = bsy1;
            if (ov1) beats.push_back(od1);
        end
        checks++;
        if (gr.size() < 6 || beats.size() < 6) begin
            failures++;
            $display("FAIL wrap_count grants=%0d beats=%0d required >=6", gr.size(), beats.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (gr[i] !== ((i % 2 == 0) ? 2'd3 : 2'd0) || beats[i] !== ((i % 2 == 0) ? 4'h9 : 4'h5)) begin
                    failures++;
                    $display("FAIL wrap_seq step%0d got id=%0d data=%h", i, gr[i], beats[i]);
                end
            end
        end
        in_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rstb = ($urandom_range(0, 99) != 0);
            in_valid = 4'($urandom) | 4'($urandom);
            in_data = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dut_obs(m) !== mdl_obs(m)) begin
                    failures++;
                    $display("FAIL random_model dut%0d t=%0t got=%h required=%h", m, $time, dut_obs(m), mdl_obs(m));
                end
            end
        end
        rstb = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_fairness();
        test_backpressure();
        test_early_release();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
